// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: RMII receive framer. Samples CRS_DV/RXD, strips preamble and
// SFD, resolves CRS_DV toggling at carrier loss and emits the frame as an
// LSB-dibit-first stream with a done/err pulse at end of frame.
// Optional FCS check: define RMII_RX_FCS_CHECK_EN.
module rmii_rx_framer #(
  parameter int unsigned MIN_PREAMBLE_DIBITS = 16,
  parameter int unsigned MAX_FRAME_BYTES     = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       outclk,
  output logic [1:0] out,
  output logic       done,
  output logic       err,
  output logic       fcs_ok
);

  localparam int unsigned PCNT_W = $clog2(MIN_PREAMBLE_DIBITS + 1);
  localparam int unsigned DCNT_W = $clog2(4 * MAX_FRAME_BYTES + 1);
  localparam logic [PCNT_W-1:0] PCNT_MIN = PCNT_W'(MIN_PREAMBLE_DIBITS);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(4 * MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    DROP,
    IDLE,
    PREAMBLE,
    DATA
  } state_t;

  state_t            state_q;
  logic              c1_q, c2_q;
  logic [1:0]        d1_q, d2_q;
  logic [PCNT_W-1:0] pcnt_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic              outclk_q, done_q, err_q;
  logic [1:0]        out_q;
  logic              dib_valid;
  logic              line_quiet;
  logic              dribble;

  // Two-deep input pipeline: stage 2 holds sample t, stage 1 holds sample t+1.
  // CRS_DV stages reset to 1 so that a reset mid-frame still waits for two real
  // quiet samples before re-arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= 1'b1;
      c2_q <= 1'b1;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      c1_q <= crsdv;
      d1_q <= rxd;
      c2_q <= c1_q;
      d2_q <= d1_q;
    end
  end

  // Dibit validity and end-of-frame detection from the two-sample window.
  always_comb begin
    dib_valid  = c2_q | c1_q;
    line_quiet = ~c2_q & ~c1_q;
    dribble    = |dcnt_q[1:0];
  end

`ifdef RMII_RX_FCS_CHECK_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        fcs_ok_q;
  logic        crc_good;

  function automatic logic [31:0] crc_dibit(input logic [31:0] crc_in,
                                            input logic [1:0]  dib);
    logic [31:0] c;
    logic        fb;
    c = crc_in;
    for (int unsigned i = 0; i < 2; i++) begin
      fb = c[0] ^ dib[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  // Next CRC value for the dibit currently at the head of the pipeline.
  always_comb begin
    crc_d    = crc_dibit(crc_q, d2_q);
    crc_good = (crc_q == CRC_RESIDUE);
  end
`endif

  // Framing state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DROP;
      pcnt_q   <= '0;
      dcnt_q   <= '0;
      outclk_q <= 1'b0;
      out_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
      crc_q    <= '1;
      fcs_ok_q <= 1'b0;
`endif
    end else begin
      outclk_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef RMII_RX_FCS_CHECK_EN
      fcs_ok_q <= 1'b0;
`endif
      case (state_q)
        DROP: begin
          if (line_quiet) state_q <= IDLE;
        end
        IDLE: begin
          if (c2_q) begin
            if (d2_q == 2'b01) begin
              state_q <= PREAMBLE;
              pcnt_q  <= PCNT_W'(1);
            end else if (d2_q == 2'b10) begin
              state_q <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!c2_q) begin
            state_q <= DROP;
          end else if (d2_q == 2'b01) begin
            // Saturating at the minimum is enough; only the threshold matters.
            if (pcnt_q < PCNT_MIN) pcnt_q <= pcnt_q + PCNT_W'(1);
          end else if (d2_q == 2'b11 && pcnt_q >= PCNT_MIN) begin
            state_q <= DATA;
            dcnt_q  <= '0;
`ifdef RMII_RX_FCS_CHECK_EN
            crc_q   <= '1;
`endif
          end else begin
            state_q <= DROP;
          end
        end
        DATA: begin
          if (dib_valid) begin
            if (dcnt_q == DCNT_MAX) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= DROP;
            end else begin
              outclk_q <= 1'b1;
              out_q    <= d2_q;
              dcnt_q   <= dcnt_q + DCNT_W'(1);
`ifdef RMII_RX_FCS_CHECK_EN
              crc_q    <= crc_d;
`endif
            end
          end else begin
            done_q  <= 1'b1;
            state_q <= IDLE;
`ifdef RMII_RX_FCS_CHECK_EN
            err_q    <= dribble | ~crc_good;
            fcs_ok_q <= crc_good;
`else
            err_q    <= dribble;
`endif
          end
        end
        default: state_q <= DROP;
      endcase
    end
  end

  assign outclk = outclk_q;
  assign out    = out_q;
  assign done   = done_q;
  assign err    = err_q;
`ifdef RMII_RX_FCS_CHECK_EN
  assign fcs_ok = fcs_ok_q;
`else
  assign fcs_ok = 1'b0;
`endif

endmodule

// File: tb/tb_rmii_rx_framer.sv
// tb_rmii_rx_framer: directed bench for rmii_rx_framer. A small instance
// (MAX_FRAME_BYTES=4) covers framing; a full-size instance covers the FCS frame.
module tb_rmii_rx_framer;

`ifdef RMII_RX_FCS_CHECK_EN
  localparam logic FCS = 1'b1;
`else
  localparam logic FCS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       crsdv = 1'b0;
  logic [1:0] rxd = 2'b00;
  logic       outclk, done, err, fcs_ok;
  logic [1:0] out;
  logic       f_outclk, f_done, f_err, f_fcs_ok;
  logic [1:0] f_out;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int last_edge = 0;
  int viol = 0;

  int         oc_e[$];
  logic [1:0] oc_d[$];
  int         dn_e[$];
  logic       dn_err[$];
  logic       dn_fok[$];
  logic [1:0] f_oc_d[$];
  logic       f_dn_err[$];
  logic       f_dn_fok[$];

  logic [1:0] tx_d[$];
  logic       tx_c[$];
  int         tx_e[$];

  int oc_b, dn_b, vb, fo_b, fd_b, sfd_e;

  always #10 clk = ~clk;

  rmii_rx_framer #(.MIN_PREAMBLE_DIBITS(16), .MAX_FRAME_BYTES(4)) dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .outclk(outclk), .out(out), .done(done), .err(err), .fcs_ok(fcs_ok)
  );

  rmii_rx_framer #(.MIN_PREAMBLE_DIBITS(16), .MAX_FRAME_BYTES(1522)) dut_f (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .outclk(f_outclk), .out(f_out), .done(f_done), .err(f_err), .fcs_ok(f_fcs_ok)
  );

  always @(posedge clk) edge_n <= edge_n + 1;

  // Output log, sampled mid-cycle and tagged with the last active edge number.
  always @(negedge clk) begin
    if (outclk) begin
      oc_e.push_back(edge_n);
      oc_d.push_back(out);
    end
    if (done) begin
      dn_e.push_back(edge_n);
      dn_err.push_back(err);
      dn_fok.push_back(fcs_ok);
    end
    if (f_outclk) f_oc_d.push_back(f_out);
    if (f_done) begin
      f_dn_err.push_back(f_err);
      f_dn_fok.push_back(f_fcs_ok);
    end
    if ((outclk && done) || (!done && (err || fcs_ok))) viol = viol + 1;
    if ((f_outclk && f_done) || (!f_done && (f_err || f_fcs_ok))) viol = viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic [1:0] d);
    crsdv = c;
    rxd   = d;
    @(posedge clk);
    #1;
    last_edge = edge_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    sfd_e = last_edge;
  endtask

  task automatic clear_tx();
    tx_d.delete();
    tx_c.delete();
    tx_e.delete();
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) begin
      tx_d.push_back(b[2*i +: 2]);
      tx_c.push_back(1'b1);
    end
  endtask

  task automatic load_t1();
    logic [1:0] t1d [8];
    t1d = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
    clear_tx();
    for (int i = 0; i < 8; i++) begin
      tx_d.push_back(t1d[i]);
      tx_c.push_back(1'b1);
    end
  endtask

  task automatic send_data();
    tx_e.delete();
    for (int i = 0; i < tx_d.size(); i++) begin
      drive(tx_c[i], tx_d[i]);
      tx_e.push_back(last_edge);
    end
  endtask

  task automatic mark();
    oc_b = oc_e.size();
    dn_b = dn_e.size();
    vb   = viol;
    fo_b = f_oc_d.size();
    fd_b = f_dn_err.size();
  endtask

  // Expect the first n_exp queued tx dibits on out, 2 edges after each sample,
  // then a single done at done_edge (or none if done_edge < 0).
  task automatic verify(input string tag, input int n_exp, input int done_edge,
                        input logic exp_err);
    check($sformatf("%s.n_outclk", tag), oc_e.size() - oc_b, n_exp);
    for (int i = 0; i < n_exp && oc_b + i < oc_e.size(); i++) begin
      check($sformatf("%s.dib%0d", tag, i), oc_d[oc_b + i], tx_d[i]);
      check($sformatf("%s.lat%0d", tag, i), oc_e[oc_b + i], tx_e[i] + 2);
    end
    if (done_edge < 0) begin
      check($sformatf("%s.n_done", tag), dn_e.size() - dn_b, 0);
    end else begin
      check($sformatf("%s.n_done", tag), dn_e.size() - dn_b, 1);
      if (dn_e.size() > dn_b) begin
        check($sformatf("%s.done_edge", tag), dn_e[dn_b], done_edge);
        check($sformatf("%s.err", tag), dn_err[dn_b], exp_err);
        check($sformatf("%s.fcs_ok", tag), dn_fok[dn_b], 1'b0);
      end
    end
    check($sformatf("%s.excl", tag), viol - vb, 0);
  endtask

  task automatic fcs_frame(input string tag, input logic [7:0] first, input logic exp_err,
                           input logic exp_fok);
    logic [7:0] msg [13];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    msg[0] = first;
    clear_tx();
    for (int i = 0; i < 13; i++) add_byte(msg[i]);
    mark();
    preamble(31);
    send_data();
    idle(4);
    check($sformatf("%s.n_outclk", tag), f_oc_d.size() - fo_b, 52);
    if (f_oc_d.size() > fo_b) check($sformatf("%s.dib0", tag), f_oc_d[fo_b], first[1:0]);
    check($sformatf("%s.n_done", tag), f_dn_err.size() - fd_b, 1);
    if (f_dn_err.size() > fd_b) begin
      check($sformatf("%s.err", tag), f_dn_err[fd_b], exp_err);
      check($sformatf("%s.fcs_ok", tag), f_dn_fok[fd_b], exp_fok);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs", {outclk, out, done, err, fcs_ok}, 0);
    check("reset.f_outs", {f_outclk, f_out, f_done, f_err, f_fcs_ok}, 0);
    rst = 1'b0;
    idle(3);

    // 1: basic two-byte frame
    load_t1();
    mark();
    preamble(31);
    send_data();
    idle(4);
    verify("t1", 8, tx_e[7] + 3, FCS);

    // 2: CRS_DV toggling over the last four dibits
    load_t1();
    tx_c[4] = 1'b0;
    tx_c[6] = 1'b0;
    mark();
    preamble(31);
    send_data();
    idle(4);
    verify("t2", 8, tx_e[7] + 3, FCS);

    // 3: short preamble rejected, framer re-arms for the next frame
    load_t1();
    mark();
    preamble(8);
    for (int i = 0; i < 8; i++) drive(1'b1, tx_d[i]);
    idle(2);
    preamble(31);
    send_data();
    idle(4);
    verify("t3", 8, tx_e[7] + 3, FCS);

    // zero-byte frame
    clear_tx();
    mark();
    preamble(20);
    idle(4);
    verify("zero", 0, sfd_e + 3, FCS);

    // 4: dribble
    clear_tx();
    add_byte(8'h12);
    tx_d.push_back(2'b11); tx_c.push_back(1'b1);
    tx_d.push_back(2'b01); tx_c.push_back(1'b1);
    tx_d.push_back(2'b10); tx_c.push_back(1'b1);
    mark();
    preamble(31);
    send_data();
    idle(4);
    verify("t4", 7, tx_e[6] + 3, 1'b1);

    // exactly MAX_FRAME_BYTES
    clear_tx();
    add_byte(8'h12); add_byte(8'h34); add_byte(8'h56); add_byte(8'h78);
    mark();
    preamble(31);
    send_data();
    idle(4);
    verify("max", 16, tx_e[15] + 3, FCS);

    // 5: overlong frame aborted in place of the 17th dibit
    clear_tx();
    add_byte(8'h12); add_byte(8'h34); add_byte(8'h56); add_byte(8'h78); add_byte(8'h9A);
    mark();
    preamble(31);
    send_data();
    idle(4);
    verify("t5", 16, tx_e[16] + 2, 1'b1);

    // 6: reset mid-frame while carrier stays up
    load_t1();
    preamble(31);
    for (int i = 0; i < 4; i++) drive(1'b1, tx_d[i]);
    rst = 1'b1;
    drive(1'b1, 2'b01);
    rst = 1'b0;
    check("t6.rst_outs", {outclk, out, done, err, fcs_ok}, 0);
    mark();
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) drive(1'b1, tx_d[i]);
    idle(2);
    preamble(31);
    send_data();
    idle(4);
    verify("t6", 8, tx_e[7] + 3, FCS);

    // 7: CRC check frame ("123456789" + FCS) and a one-bit corruption
    fcs_frame("t7.good", 8'h31, 1'b0, FCS);
    fcs_frame("t7.bad", 8'h30, FCS, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
